// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle resource among four requesters.
// One transaction at a time: grant, issue, wait LATENCY cycles, return result.
module bus_share_arbiter #(
    parameter int LATENCY = 2,
    parameter int NREQ    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [5*NREQ-1:0]   req_i0,
    input  logic [5*NREQ-1:0]   req_i1,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [2:-2]         rsp_o0,
    output logic [-2:2]         rsp_o1,
    output logic [2:-2]         res_i0,
    output logic [-2:2]         res_i1,
    output logic                res_start,
    input  logic [2:-2]         res_o0,
    input  logic [-2:2]         res_o1
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_ptr;
    logic [1:0]  r_winner;
    logic [3:0]  r_cnt;
    logic [2:-2] r_opA;
    logic [-2:2] r_opB;
    logic [2:-2] r_resA;
    logic [-2:2] r_resB;

    logic        w_found;
    logic [1:0]  w_winIdx;
    logic [1:0]  w_cand;
    logic [4:0]  w_opA [NREQ];
    logic [4:0]  w_opB [NREQ];

    // Unpack the per-requester operand fields so the winner can index them.
    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            w_opA[n] = req_i0[5*n +: 5];
            w_opB[n] = req_i1[5*n +: 5];
        end
    end

    // Scan upward starting just after the last winner; 2-bit wrap gives modulo 4.
    always_comb begin
        w_found  = 1'b0;
        w_winIdx = r_ptr;
        w_cand   = r_ptr;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winIdx = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant is suppressed while reset is held so nothing leaks out mid-reset.
    always_comb begin
        w_nextState = r_state;
        gnt         = '0;
        done        = '0;
        res_start   = 1'b0;
        rsp_o0      = '0;
        rsp_o1      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !rst) begin
                    gnt         = NREQ'(1) << w_winIdx;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                res_start   = 1'b1;
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = ST_RETURN;
                end
            end
            ST_RETURN: begin
                done        = NREQ'(1) << r_winner;
                rsp_o0      = r_resA;
                rsp_o1      = r_resB;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= 2'd3;
            r_winner <= 2'd0;
            r_cnt    <= 4'd0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_resA   <= '0;
            r_resB   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_winner <= w_winIdx;
                        r_opA    <= w_opA[w_winIdx];
                        r_opB    <= w_opB[w_winIdx];
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= CNT_LOAD;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_resA <= res_o0;
                        r_resB <= res_o1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RETURN: begin
                    r_ptr <= r_winner;
                end
                default: begin
                end
            endcase
        end
    end

    // Operands stay latched from grant until the next grant, covering issue through capture.
    assign res_i0 = r_opA;
    assign res_i1 = r_opB;

endmodule
